// File: rtl/v8x3_scan_encoder.sv
// v8x3_scan_encoder: captures an 8-bit flag vector and emits the index of each set bit, one per handshake
module v8x3_scan_encoder #(
    parameter int MSB_FIRST = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] D,
    input  logic       ready,
    output logic [2:0] Y,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] count
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    state_t     state, state_n;
    logic [7:0] pend, pend_n;
    logic [3:0] count_n;
    logic [2:0] idx;
    // priority pick: the last match in scan order wins, so scan away from the preferred end
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend[MSB_FIRST != 0 ? i : 7 - i]) idx = 3'(MSB_FIRST != 0 ? i : 7 - i);
        end
    end
    // next state, pending bits and accepted-index count
    always_comb begin
        state_n = state;
        pend_n  = pend;
        count_n = count;
        case (state)
            IDLE: if (start) begin
                pend_n  = D;
                count_n = 4'd0;
                state_n = D != 8'd0 ? EMIT : DONE;
            end
            EMIT: if (ready) begin
                pend_n  = pend & ~(8'b1 << idx);
                count_n = count + 4'd1;
                state_n = pend_n == 8'd0 ? DONE : EMIT;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // state register; reset overrides any pending handshake or load
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pend  <= 8'd0;
            count <= 4'd0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            count <= count_n;
        end
    end
    assign valid = state == EMIT;
    assign busy  = state != IDLE;
    assign done  = state == DONE;
    assign Y     = valid ? idx : 3'd0;
endmodule

// File: doc/v8x3_scan_encoder.md
# v8x3_scan_encoder

Sequential 8-to-3 encoder, the encoding counterpart of the v3x8_decoder in the v74x139 lab project. It captures an 8-bit one-hot or multi-hot vector and emits the 3-bit binary index of every asserted bit, one per accepted handshake, in priority order. It sits between a request/flag register and any consumer that needs indices, such as a downstream 3x8 decoder or a display driver.

## Interface
- MSB_FIRST, default 0: 0 = emit lowest set bit first; 1 = emit highest set bit first.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- start  in  1  load request; honoured only in IDLE.
- D  in  8  input vector; D[i]=1 means index i is to be emitted.
- ready  in  1  consumer accepts Y when valid=1.
- Y  out  3  encoded index of current priority bit; 3'b000 when valid=0.
- valid  out  1  Y holds a valid index.
- busy  out  1  block is not in IDLE.
- done  out  1  one-cycle pulse, end of sequence.
- count  out  4  number of indices accepted since last load (0..8).

## Operation
- Registers: state (IDLE, EMIT, DONE), pend[7:0], count[3:0].
- Reset: state=IDLE, pend=0, count=0; outputs Y=0, valid=0, busy=0, done=0, count=0.
- IDLE: busy=0, valid=0. When start=1, pend<=D and count<=0. The next state is EMIT if D!=0; otherwise it is DONE.
- EMIT: valid=1, busy=1.
  - Y is the index of the lowest set bit of pend, or the highest set bit when MSB_FIRST=1.
  - On valid&&ready, that bit of pend is cleared and count increments.
  - If the cleared pend is 0, the next state is DONE. Otherwise the block stays in EMIT and presents the next index.
- DONE: done=1, busy=1, valid=0. The next state is IDLE unconditionally.
- start is ignored outside IDLE. D is sampled only on the accepting edge, and later changes to D have no effect on the current sequence.
- Y, valid, busy and done decode from registered state and pend only. There is no combinational path from any input to any output.
- count saturates naturally at 8 (D=8'hFF), and the 4-bit width covers this. count holds its value through DONE and IDLE until the next accepted start.

## Timing
- Accept start at edge k: valid=1 with the first Y during cycle k+1.
- Throughput: 1 index per cycle while ready=1. N set bits with ready held high give done at cycle k+N+1 and busy low at cycle k+N+2.
- Backpressure: while valid=1 and ready=0, Y, pend and count hold stable. Y may not change until the handshake completes.
- D=0: done pulses in cycle k+1 with no valid, count=0, and IDLE is reached in k+2.
- start=1 during the DONE cycle is ignored. The earliest reload is the first IDLE cycle after DONE.
- reset has priority over all other inputs at any state, including mid-EMIT with an outstanding valid. At the next edge all outputs return to reset values and the remaining pend bits are discarded.
- reset and start asserted on the same edge: reset wins and D is not captured.

## Test plan
- Reset: assert reset 2 cycles with start=1, D=8'hFF -> Y=0, valid=0, busy=0, done=0, count=0 afterwards, and no sequence is started.
- Single bit, MSB_FIRST=0: start with D=8'b0010_0000, ready=1 -> one valid cycle with Y=5, done pulses next cycle, count=1.
- Multi-hot order: D=8'b1001_0110, ready=1 -> Y sequence 1,2,4,7 on consecutive cycles, done after, count=4. With MSB_FIRST=1 the sequence is 7,4,2,1.
- Backpressure: D=8'hFF, ready toggles 1,0,0,1,... -> Y values 0..7 each held stable while ready=0, no index skipped or repeated, count=8, and D changes mid-sequence are ignored.
- Empty input: start with D=8'h00 -> valid never asserts, done pulses 1 cycle after start, count=0, and start during DONE is ignored.
- Reset mid-sequence: D=8'hC3, assert reset after 2 accepts -> next edge gives valid=0, busy=0, count=0. A subsequent start with D=8'h08 yields only Y=3.
